frame_seq_ctrl: RTL and testbench
=================================

Name: frame_seq_ctrl

Overview:
Sequencer that drives the pixel-streaming datapath between the image source and the image sink, one frame per start request. It generates VSYNC, HSYNC, the pixel read address and the row/column indices, inserts programmable blanking between lines, and honours a downstream stall. It reports completion with a one-cycle ctrl_done and counts completed frames. It sits between the testbench or top-level control and the image source's memory/readout path.

Parameters:
WIDTH, 768, pixels per line (>=1)
HEIGHT, 512, lines per frame (>=1)
HBLANK, 160, idle cycles between lines (0 allowed)
START_DELAY, 100, VSYNC-high cycles before first line (>=1)
ADDR_W, 20, read address width (must satisfy 2^ADDR_W >= WIDTH*HEIGHT)

Ports:
HCLK  in  1  clock, all logic on rising edge
HRESET  in  1  synchronous reset, active-high
start  in  1  frame request, sampled in IDLE only
stall  in  1  downstream not ready; freezes pixel advance
busy  out  1  high in any state other than IDLE
VSYNC  out  1  high during PRE state
HSYNC  out  1  high on cycles a valid pixel is issued
rd_addr  out  ADDR_W  linear pixel address, valid when HSYNC=1
row  out  16  current line index
col  out  16  current pixel index in line
ctrl_done  out  1  one-cycle pulse at end of frame
frame_cnt  out  8  completed frames, wraps 255->0

Behaviour:
- Clock HCLK only; reset HRESET synchronous, active-high. All outputs registered.
- Reset (incl. mid-frame): next edge -> IDLE; busy, VSYNC, HSYNC, ctrl_done = 0; rd_addr, row, col, frame_cnt = 0. No ctrl_done for an aborted frame.
- States: IDLE, PRE, ACTIVE, HBLK, DONE.
- IDLE: start=1 on edge k -> PRE from cycle k+1; busy=1.
- PRE: VSYNC=1 exactly START_DELAY cycles; then ACTIVE with row=0, col=0, rd_addr=0.
- ACTIVE, stall=0: HSYNC=1, pixel (row,col,rd_addr) issued; next cycle col+1, rd_addr+1.
- ACTIVE, stall=1: HSYNC=0; row/col/rd_addr hold; no state change. stall ignored outside ACTIVE.
- End of line (col=WIDTH-1 issued): row<HEIGHT-1 -> HBLK (or directly ACTIVE with row+1, col=0 if HBLANK=0); row=HEIGHT-1 -> DONE.
- HBLK: HSYNC=0 for HBLANK cycles; then ACTIVE, row+1, col=0; rd_addr continues from last+1 (no multiplier; address is an incrementing counter).
- DONE: one cycle, ctrl_done=1, frame_cnt+1 (mod 256); then IDLE, busy=0.
- start while busy: ignored, not queued. start held high across DONE->IDLE: new frame starts on first IDLE cycle.
- Min frame length with no stall: START_DELAY + HEIGHT*WIDTH + (HEIGHT-1)*HBLANK + 1 cycles from start-sampled edge to ctrl_done inclusive.

Optional Feature:
BOTTOM_UP_EN: when defined, lines are issued bottom-up to match BMP storage: row counts HEIGHT-1 down to 0, rd_addr starts at (HEIGHT-1)*WIDTH, increments within a line and steps back 2*WIDTH-1 at each line end; frame ends after row 0. When undefined, top-down order as above. State timing, HSYNC/VSYNC and ctrl_done identical in both builds.

Test Plan:
WIDTH=4, HEIGHT=3, HBLANK=2, START_DELAY=3, start pulse sampled cycle 0 -> VSYNC cycles 1-3; HSYNC cycles 4-7, 10-13, 16-19; rd_addr 0..11 in order; ctrl_done only cycle 20; frame_cnt=1; busy=0 cycle 21.
Same config, stall=1 on cycles 5-6 -> HSYNC low 5-6, rd_addr=1 held, all later events shifted +2, ctrl_done cycle 22, no address skipped or repeated.
HRESET=1 at cycle 12 -> cycle 13 IDLE, all outputs 0, no ctrl_done; new start then gives a clean full frame from rd_addr 0.
start pulses at cycles 5 and 15 while busy -> ignored; exactly one ctrl_done; start held high continuously -> back-to-back frames, frame_cnt 255->0 wrap after 256 frames.
HBLANK=0, WIDTH=1, HEIGHT=1 -> one HSYNC cycle (rd_addr=0) after VSYNC, ctrl_done next cycle.
BOTTOM_UP_EN defined, base config -> rd_addr sequence 8,9,10,11,4,5,6,7,0,1,2,3; row 2,1,0; timing identical to first scenario.

Source files
------------

// File: rtl/frame_seq_ctrl.sv
// Frame sequencer: VSYNC preamble, per-pixel HSYNC/address/row/col, line blanking, stall, done pulse.
// Optional build macro BOTTOM_UP_EN issues lines bottom-up (last line first) with identical timing.
module frame_seq_ctrl #(
    parameter int unsigned WIDTH       = 768,
    parameter int unsigned HEIGHT      = 512,
    parameter int unsigned HBLANK      = 160,
    parameter int unsigned START_DELAY = 100,
    parameter int unsigned ADDR_W      = 20
) (
    input  logic              HCLK,
    input  logic              HRESET,
    input  logic              start,
    input  logic              stall,
    output logic              busy,
    output logic              VSYNC,
    output logic              HSYNC,
    output logic [ADDR_W-1:0] rd_addr,
    output logic [15:0]       row,
    output logic [15:0]       col,
    output logic              ctrl_done,
    output logic [7:0]        frame_cnt
);

    typedef enum logic [2:0] {StIdle, StPre, StActive, StHblk, StDone} state_e;

    localparam int unsigned CNT_MAX = (START_DELAY > HBLANK) ? START_DELAY : HBLANK;
    localparam int unsigned CNT_W   = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;

    localparam logic [CNT_W-1:0] PRE_LAST  = CNT_W'(START_DELAY - 1);
    localparam logic [CNT_W-1:0] HBLK_LAST = (HBLANK > 0) ? CNT_W'(HBLANK - 1) : '0;
    localparam logic [15:0]      COL_LAST  = 16'(WIDTH - 1);

`ifdef BOTTOM_UP_EN
    localparam logic [15:0]       ROW_FIRST  = 16'(HEIGHT - 1);
    localparam logic [15:0]       ROW_LAST   = 16'd0;
    localparam logic [ADDR_W-1:0] ADDR_FIRST = ADDR_W'((HEIGHT - 1) * WIDTH);
`else
    localparam logic [15:0]       ROW_FIRST  = 16'd0;
    localparam logic [15:0]       ROW_LAST   = 16'(HEIGHT - 1);
    localparam logic [ADDR_W-1:0] ADDR_FIRST = '0;
`endif

    state_e             state_q;
    logic [CNT_W-1:0]   cnt_q;
    logic [15:0]        row_step;
    logic [ADDR_W-1:0]  addr_step;

    // Row index and first address of the following line, from the last pixel of this one.
    always_comb begin
`ifdef BOTTOM_UP_EN
        row_step  = row - 16'd1;
        addr_step = rd_addr - ADDR_W'(2 * WIDTH - 1);
`else
        row_step  = row + 16'd1;
        addr_step = rd_addr + ADDR_W'(1);
`endif
    end

    always_ff @(posedge HCLK) begin
        if (HRESET) begin
            state_q   <= StIdle;
            cnt_q     <= '0;
            busy      <= 1'b0;
            VSYNC     <= 1'b0;
            HSYNC     <= 1'b0;
            rd_addr   <= '0;
            row       <= '0;
            col       <= '0;
            ctrl_done <= 1'b0;
            frame_cnt <= '0;
        end else begin
            ctrl_done <= 1'b0;
            unique case (state_q)
                StIdle: begin
                    if (start) begin
                        state_q <= StPre;
                        cnt_q   <= '0;
                        busy    <= 1'b1;
                        VSYNC   <= 1'b1;
                    end
                end
                StPre: begin
                    if (cnt_q == PRE_LAST) begin
                        state_q <= StActive;
                        VSYNC   <= 1'b0;
                        HSYNC   <= 1'b1;
                        row     <= ROW_FIRST;
                        col     <= '0;
                        rd_addr <= ADDR_FIRST;
                    end else begin
                        cnt_q <= cnt_q + CNT_W'(1);
                    end
                end
                StActive: begin
                    // HSYNC high means the current pixel is issued this cycle; otherwise it is
                    // held. Stall sampled at this edge gates the next cycle's HSYNC.
                    if (HSYNC) begin
                        if (col == COL_LAST) begin
                            if (row == ROW_LAST) begin
                                state_q   <= StDone;
                                HSYNC     <= 1'b0;
                                ctrl_done <= 1'b1;
                                frame_cnt <= frame_cnt + 8'd1;
                            end else if (HBLANK == 0) begin
                                row     <= row_step;
                                col     <= '0;
                                rd_addr <= addr_step;
                                HSYNC   <= ~stall;
                            end else begin
                                state_q <= StHblk;
                                cnt_q   <= '0;
                                HSYNC   <= 1'b0;
                            end
                        end else begin
                            col     <= col + 16'd1;
                            rd_addr <= rd_addr + ADDR_W'(1);
                            HSYNC   <= ~stall;
                        end
                    end else begin
                        HSYNC <= ~stall;
                    end
                end
                StHblk: begin
                    if (cnt_q == HBLK_LAST) begin
                        state_q <= StActive;
                        HSYNC   <= 1'b1;
                        row     <= row_step;
                        col     <= '0;
                        rd_addr <= addr_step;
                    end else begin
                        cnt_q <= cnt_q + CNT_W'(1);
                    end
                end
                StDone: begin
                    state_q <= StIdle;
                    busy    <= 1'b0;
                end
                default: begin
                    state_q <= StIdle;
                    busy    <= 1'b0;
                    VSYNC   <= 1'b0;
                    HSYNC   <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_frame_seq_ctrl.sv
// Directed bench for frame_seq_ctrl: 4x3 frame with blanking, stall, reset abort, ignored starts,
// back-to-back frames with frame_cnt wrap, and a 1x1 frame on a second instance.
module tb_frame_seq_ctrl;

    bit clk = 1'b0;
    always #5 clk = ~clk;

    logic        HRESET = 1'b1;
    logic        start  = 1'b0;
    logic        stall  = 1'b0;
    logic        busy, VSYNC, HSYNC, ctrl_done;
    logic [19:0] rd_addr;
    logic [15:0] row, col;
    logic [7:0]  frame_cnt;

    logic        start2 = 1'b0;
    logic        busy2, VSYNC2, HSYNC2, ctrl_done2;
    logic [19:0] rd_addr2;
    logic [15:0] row2, col2;
    logic [7:0]  frame_cnt2;

    int n_assert = 0;
    int n_fail   = 0;

`ifdef BOTTOM_UP_EN
    int exp_addr [12] = '{8, 9, 10, 11, 4, 5, 6, 7, 0, 1, 2, 3};
    int exp_row  [12] = '{2, 2, 2, 2, 1, 1, 1, 1, 0, 0, 0, 0};
`else
    int exp_addr [12] = '{0, 1, 2, 3, 4, 5, 6, 7, 8, 9, 10, 11};
    int exp_row  [12] = '{0, 0, 0, 0, 1, 1, 1, 1, 2, 2, 2, 2};
`endif
    int exp_col  [12] = '{0, 1, 2, 3, 0, 1, 2, 3, 0, 1, 2, 3};

    frame_seq_ctrl #(
        .WIDTH(4), .HEIGHT(3), .HBLANK(2), .START_DELAY(3), .ADDR_W(20)
    ) u_dut (
        .HCLK(clk), .HRESET(HRESET), .start(start), .stall(stall),
        .busy(busy), .VSYNC(VSYNC), .HSYNC(HSYNC), .rd_addr(rd_addr),
        .row(row), .col(col), .ctrl_done(ctrl_done), .frame_cnt(frame_cnt)
    );

    frame_seq_ctrl #(
        .WIDTH(1), .HEIGHT(1), .HBLANK(0), .START_DELAY(1), .ADDR_W(20)
    ) u_small (
        .HCLK(clk), .HRESET(HRESET), .start(start2), .stall(1'b0),
        .busy(busy2), .VSYNC(VSYNC2), .HSYNC(HSYNC2), .rd_addr(rd_addr2),
        .row(row2), .col(col2), .ctrl_done(ctrl_done2), .frame_cnt(frame_cnt2)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] req);
        n_assert++;
        assert (obs === req) else begin
            n_fail++;
            $error("FAIL %s: observed %0d required %0d", tag, obs, req);
        end
    endtask

    // HSYNC cycles for the 4x3 frame: 4-7, 10-13, 16-19 free-running;
    // with the two stalled cycles after the first pixel: 4, 7-9, 12-15, 18-21.
    function automatic bit hs_plain(input int c);
        return (c >= 4 && c <= 7) || (c >= 10 && c <= 13) || (c >= 16 && c <= 19);
    endfunction

    function automatic bit hs_stall(input int c);
        return (c == 4) || (c >= 7 && c <= 9) || (c >= 12 && c <= 15) || (c >= 18 && c <= 21);
    endfunction

    // Start sampled at edge 0; cycle c is observed just after edge c-1.
    task automatic run_frame(input bit with_stall, input int fc);
        int  pix;
        int  last;
        bit  hs;
        pix  = 0;
        last = with_stall ? 22 : 20;
        start = 1'b1;
        step();
        start = 1'b0;
        for (int c = 1; c <= last + 1; c++) begin
            if (c > 1) step();
            hs = with_stall ? hs_stall(c) : hs_plain(c);
            chk("vsync", 32'(VSYNC), 32'(c <= 3));
            chk("hsync", 32'(HSYNC), 32'(hs));
            chk("busy", 32'(busy), 32'(c <= last));
            chk("ctrl_done", 32'(ctrl_done), 32'(c == last));
            if (hs && pix < 12) begin
                chk("rd_addr", 32'(rd_addr), 32'(exp_addr[pix]));
                chk("row", 32'(row), 32'(exp_row[pix]));
                chk("col", 32'(col), 32'(exp_col[pix]));
                pix++;
            end
            if (with_stall && (c == 5 || c == 6)) chk("stall_hold_addr", 32'(rd_addr), 32'(exp_addr[1]));
            if (c == last) chk("frame_cnt", 32'(frame_cnt), 32'(fc));
            // Registered outputs: stall driven in cycles 4-5 holds HSYNC low in cycles 5-6.
            stall = with_stall && (c == 4 || c == 5);
        end
        stall = 1'b0;
    endtask

    initial begin
        int dones;
        int frames;
        int last_done;
        int gap;

        step();
        step();
        HRESET = 1'b0;
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_vsync", 32'(VSYNC), 32'd0);
        chk("rst_hsync", 32'(HSYNC), 32'd0);
        chk("rst_done", 32'(ctrl_done), 32'd0);
        chk("rst_addr", 32'(rd_addr), 32'd0);
        chk("rst_row", 32'(row), 32'd0);
        chk("rst_col", 32'(col), 32'd0);
        chk("rst_fcnt", 32'(frame_cnt), 32'd0);

        // Plain frame, then a stalled frame.
        run_frame(1'b0, 1);
        run_frame(1'b1, 2);

        // Start pulses at cycles 5 and 15 while busy are ignored.
        dones = 0;
        start = 1'b1;
        step();
        start = 1'b0;
        for (int c = 1; c <= 30; c++) begin
            if (c > 1) step();
            if (ctrl_done) begin
                dones++;
                chk("busy_start_done_cycle", 32'(c), 32'd20);
            end
            start = (c == 5 || c == 15);
        end
        start = 1'b0;
        chk("busy_start_done_count", 32'(dones), 32'd1);
        chk("busy_start_fcnt", 32'(frame_cnt), 32'd3);
        chk("busy_start_idle", 32'(busy), 32'd0);

        // Reset mid-frame at cycle 12.
        start = 1'b1;
        step();
        start = 1'b0;
        for (int c = 2; c <= 12; c++) step();
        chk("pre_abort_busy", 32'(busy), 32'd1);
        HRESET = 1'b1;
        step();
        HRESET = 1'b0;
        chk("abort_busy", 32'(busy), 32'd0);
        chk("abort_hsync", 32'(HSYNC), 32'd0);
        chk("abort_vsync", 32'(VSYNC), 32'd0);
        chk("abort_addr", 32'(rd_addr), 32'd0);
        chk("abort_row", 32'(row), 32'd0);
        chk("abort_col", 32'(col), 32'd0);
        chk("abort_fcnt", 32'(frame_cnt), 32'd0);
        chk("abort_done", 32'(ctrl_done), 32'd0);
        dones = 0;
        for (int c = 0; c < 10; c++) begin
            step();
            if (ctrl_done) dones++;
        end
        chk("abort_no_done", 32'(dones), 32'd0);
        run_frame(1'b0, 1);

        // 1x1 frame, no blanking, one-cycle preamble.
        start2 = 1'b1;
        step();
        start2 = 1'b0;
        chk("small_vsync_c1", 32'(VSYNC2), 32'd1);
        chk("small_hsync_c1", 32'(HSYNC2), 32'd0);
        step();
        chk("small_vsync_c2", 32'(VSYNC2), 32'd0);
        chk("small_hsync_c2", 32'(HSYNC2), 32'd1);
        chk("small_addr_c2", 32'(rd_addr2), 32'd0);
        chk("small_done_c2", 32'(ctrl_done2), 32'd0);
        step();
        chk("small_hsync_c3", 32'(HSYNC2), 32'd0);
        chk("small_done_c3", 32'(ctrl_done2), 32'd1);
        chk("small_fcnt_c3", 32'(frame_cnt2), 32'd1);
        step();
        chk("small_busy_c4", 32'(busy2), 32'd0);
        chk("small_done_c4", 32'(ctrl_done2), 32'd0);

        // start held high: back-to-back frames every 21 cycles, frame_cnt wraps after 256.
        HRESET = 1'b1;
        step();
        HRESET = 1'b0;
        chk("wrap_rst_fcnt", 32'(frame_cnt), 32'd0);
        frames    = 0;
        last_done = 0;
        start     = 1'b1;
        for (int c = 1; c <= 6000 && frames < 256; c++) begin
            step();
            if (ctrl_done) begin
                frames++;
                if (frames > 1) begin
                    gap = c - last_done;
                    chk("b2b_gap", 32'(gap), 32'd21);
                end
                chk("b2b_fcnt", 32'(frame_cnt), 32'(frames % 256));
                last_done = c;
            end
        end
        start = 1'b0;
        chk("b2b_frames", 32'(frames), 32'd256);
        chk("wrap_fcnt_zero", 32'(frame_cnt), 32'd0);
        step();
        chk("b2b_idle", 32'(busy), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
